// File: rtl/sid_oscillator.sv
// SID voice oscillator: 24-bit phase accumulator, 23-bit noise LFSR and a three-stage
// waveform compose pipeline. Define SID_COMBINED_WAVE_EN to take saw+tri from the ROM.
module sid_oscillator (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] freq,
    input  logic [11:0] pw,
    input  logic [7:0]  control,
    input  logic        sync_in,
    input  logic        ring_msb_in,
    output logic [11:0] table_addr,
    input  logic [7:0]  table_data,
    output logic [11:0] wave_out,
    output logic        wave_valid,
    output logic        msb_out,
    output logic        msb_rise
);

    logic [23:0] acc_q, acc_d;
    logic [22:0] lfsr_q, lfsr_d;
    logic [11:0] wave_q, wave_d;
    logic        valid_q, valid_d;
    logic        rise_q, rise_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;

    logic        test_bit;
    logic        ring_m;
    logic [11:0] saw_w, tri_w, pulse_w, noise_w, mix_w;

    assign test_bit = control[3];

    always_comb begin
        ring_m  = acc_q[23] ^ (control[2] & ring_msb_in);
        saw_w   = acc_q[23:12];
        tri_w   = {acc_q[22:12] ^ {11{ring_m}}, 1'b0};
        pulse_w = (test_bit || (acc_q[23:12] >= pw)) ? 12'hFFF : 12'h000;
        noise_w = {lfsr_q[20], lfsr_q[18], lfsr_q[14], lfsr_q[11],
                   lfsr_q[9], lfsr_q[5], lfsr_q[2], lfsr_q[0], 4'b0};

        mix_w = '1;
        if (control[7]) mix_w = mix_w & noise_w;
        if (control[6]) mix_w = mix_w & pulse_w;
        if (control[5]) mix_w = mix_w & saw_w;
        if (control[4]) mix_w = mix_w & tri_w;
        if (control[7:4] == 4'b0000) mix_w = '0;
`ifdef SID_COMBINED_WAVE_EN
        if (control[7:4] == 4'b0011) mix_w = {table_data, 4'b0};
`endif
    end

    always_comb begin
        acc_d   = acc_q;
        lfsr_d  = lfsr_q;
        rise_d  = 1'b0;
        s1_d    = ce;
        s2_d    = s1_q;
        valid_d = s2_q;
        wave_d  = wave_q;

        if (ce) begin
            if (test_bit)
                acc_d = '0;
            else if (control[1] && sync_in)
                acc_d = '0;
            else
                acc_d = acc_q + {8'b0, freq};

            // a clear leaves acc_d[23]=0, so clearing can never look like a rise
            rise_d = ~acc_q[23] & acc_d[23];

            if (test_bit)
                lfsr_d = '1;
            else if (~acc_q[19] && acc_d[19])
                lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
        end

        // acc/lfsr are stable here because ce pulses are at least 4 clocks apart
        if (s2_q)
            wave_d = mix_w;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q   <= '0;
            lfsr_q  <= 23'h7FFFF8;
            wave_q  <= '0;
            valid_q <= 1'b0;
            rise_q  <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            lfsr_q  <= lfsr_d;
            wave_q  <= wave_d;
            valid_q <= valid_d;
            rise_q  <= rise_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    assign table_addr = acc_q[23:12];
    assign wave_out   = wave_q;
    assign wave_valid = valid_q;
    assign msb_out    = acc_q[23];
    assign msb_rise   = rise_q;

`ifdef SID_COMBINED_WAVE_EN
    logic gate_unused;
    assign gate_unused = control[0];
`else
    logic gate_unused;
    assign gate_unused = control[0] ^ (^table_data);
`endif

endmodule

// File: doc/sid_oscillator.md
SID_OSCILLATOR -- requirements
Module: sid_oscillator

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clock  in  1  system clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, synchronous and active-low.
REQ-004 ce  in  1  oscillator step enable, one clock wide; consecutive pulses at least 4 clocks apart.
REQ-005 freq  in  16  phase increment per ce.
REQ-006 pw  in  12  pulse-width threshold.
REQ-007 control  in  8  bits: [7] noise, [6] pulse, [5] saw, [4] tri, [3] test, [2] ring, [1] sync, [0] gate (unused here).
REQ-008 sync_in  in  1  MSB-rise pulse from the previous voice, coincident with ce.
REQ-009 ring_msb_in  in  1  accumulator MSB of the previous voice.
REQ-010 table_addr  out  12  address to the registered combined-waveform ROM, equal to acc[23:12].
REQ-011 table_data  in  8  ROM read data, valid 1 clock after table_addr.
REQ-012 wave_out  out  12  registered waveform sample.
REQ-013 wave_valid  out  1  one-clock strobe marking a new wave_out.
REQ-014 msb_out  out  1  acc[23].
REQ-015 msb_rise  out  1  one-clock pulse when acc[23] goes 0->1 on a ce update.

Function
REQ-016 On ce: acc (24 bits) is cleared when test=1; otherwise it is cleared when sync=1 and sync_in=1; otherwise acc <= acc + freq, mod 2^24.
REQ-017 test takes priority over sync; without ce, acc holds.
REQ-018 msb_rise is asserted in the clock following the ce update in which acc[23] went 0->1; a wrap to 0, or clearing by test or sync, never asserts it.
REQ-019 The noise LFSR is 23 bits; on a ce update where acc[19] goes 0->1 and test=0: lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]}.
REQ-020 While test=1, on each ce: lfsr <= 23'h7FFFFF.
REQ-021 Ring effective MSB: m = acc[23] ^ (ring & ring_msb_in).
REQ-022 Waveforms: saw = acc[23:12]; tri = {acc[22:12] ^ {11{m}}, 1'b0}.
REQ-023 Pulse = 12'hFFF if test=1 or acc[23:12] >= pw; otherwise 12'h000.
REQ-024 Noise = {lfsr[20], lfsr[18], lfsr[14], lfsr[11], lfsr[9], lfsr[5], lfsr[2], lfsr[0], 4'b0}.
REQ-025 Selection control[7:4]: 0000 gives 12'h000; a single bit gives that waveform; any other combination gives the bitwise AND of the selected waveforms, except as in REQ-033.
REQ-026 Pipeline: ce at cycle N, acc valid at N+1, table_data valid at N+2, wave_out registered at the N+2 edge, wave_valid high during N+3 only.
REQ-027 wave_out holds between strobes.
REQ-028 Control, pw and ring_msb_in are sampled at cycle N+2 (the compose stage).
REQ-029 A ce arriving during an in-flight sample does not corrupt it, given the spacing in REQ-004.

Reset
REQ-030 While reset_n=0 at a clock edge: acc=0, lfsr=23'h7FFFF8, wave_out=0, wave_valid=0, msb_rise=0, pipeline flags cleared.
REQ-031 Asserting reset mid-pipeline discards the in-flight sample; no wave_valid follows for it.
REQ-032 The first ce after reset release behaves as REQ-016.

Configuration
REQ-033 Macro SID_COMBINED_WAVE_EN defined: control[7:4]=0011 (saw+tri) gives wave_out = {table_data, 4'b0}.
REQ-034 Macro SID_COMBINED_WAVE_EN undefined: saw+tri gives saw & tri; table_data is ignored; table_addr is still driven.

Verification
REQ-035 Saw only, freq=16'h1000, 16 ce after reset: acc=24'h010000, wave_out=12'h010, 16 wave_valid strobes, each 3 clocks after its ce.
REQ-036 test=1 with pulse selected: acc=0, wave_out=12'hFFF, lfsr=23'h7FFFFF; after test=0 and freq=16'hFFFF, msb_rise pulses once per 256 ce (first after ce 129).
REQ-037 Pulse, pw=12'h800, freq=16'h8000: wave_out alternates 12'h000 for 256 ce and 12'hFFF for 256 ce.
REQ-038 Saw+tri, acc[23:12]=12'hFF8, ROM returns 8'hFE: with macro wave_out=12'hFE0; without macro wave_out=12'h008.
REQ-039 sync=1, sync_in=1 with ce at acc=24'h123456: next acc=0 and no msb_rise; with sync=0 the same stimulus gives acc=24'h123456+freq.
REQ-040 reset_n=0 one clock after ce: no wave_valid; acc=0, lfsr=23'h7FFFF8, wave_out=0.
